// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter for the common data bus: grants one producer per cycle and registers its tag/data.
// Define CDB_RR_ARBITER_URGENT_EN to add an urgent input that is served ahead of ordinary requests.
module cdb_rr_arbiter #(
    parameter int REQUESTERS    = 3,
    parameter int DATA_WIDTH    = 4,
    parameter int CDB_TAG_WIDTH = 4,
    localparam int IDX_W        = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic [REQUESTERS-1:0]                 req,
`ifdef CDB_RR_ARBITER_URGENT_EN
    input  logic [REQUESTERS-1:0]                 urgent,
`endif
    input  logic [REQUESTERS*CDB_TAG_WIDTH-1:0]   req_tag,
    input  logic [REQUESTERS*DATA_WIDTH-1:0]      req_data,
    output logic [REQUESTERS-1:0]                 grant,
    output logic                                  cdb_valid,
    output logic [CDB_TAG_WIDTH-1:0]              cdb_tag,
    output logic [DATA_WIDTH-1:0]                 cdb_data,
    output logic [IDX_W-1:0]                      cdb_src
);

    logic [REQUESTERS-1:0][CDB_TAG_WIDTH-1:0] tag_v;
    logic [REQUESTERS-1:0][DATA_WIDTH-1:0]    data_v;
    logic [REQUESTERS-1:0]                    mask;
    logic [IDX_W-1:0]                         rr_ptr;
    logic [IDX_W-1:0]                         nxt_ptr;
    logic [IDX_W-1:0]                         win;
    logic                                     found;
    logic                                     take;

    assign tag_v  = req_tag;
    assign data_v = req_data;

    // Scan downward in offset so the last hit is the one closest to ptr.
    function automatic logic [IDX_W:0] rr_pick(input logic [REQUESTERS-1:0] m,
                                                input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % REQUESTERS;
            if (m[idx]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

`ifdef CDB_RR_ARBITER_URGENT_EN
    assign mask = (|(req & urgent)) ? (req & urgent) : req;
`else
    assign mask = req;
`endif

    assign {found, win} = rr_pick(mask, rr_ptr);
    assign take         = found && rst_n && !flush;
    assign grant        = take ? (REQUESTERS'(1) << win) : '0;
    assign nxt_ptr      = (int'(win) == REQUESTERS - 1) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (take) begin
            rr_ptr    <= nxt_ptr;
            cdb_valid <= 1'b1;
            cdb_tag   <= tag_v[win];
            cdb_data  <= data_v[win];
            cdb_src   <= win;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Bench for cdb_rr_arbiter: directed steps, then random traffic against a queue-free scan model.
module tb_cdb_rr_arbiter;

    localparam int N  = 3;
    localparam int TW = 4;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [N-1:0]    req;
    logic [N-1:0]    urgent;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [1:0]      cdb_src;

    int errors = 0;
    int checks = 0;

    // reference state
    int            m_ptr;
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    int            m_src;

    cdb_rr_arbiter #(.REQUESTERS(N), .DATA_WIDTH(DW), .CDB_TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req(req),
`ifdef CDB_RR_ARBITER_URGENT_EN
        .urgent(urgent),
`endif
        .req_tag(req_tag), .req_data(req_data), .grant(grant),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    // first set bit found walking up from ptr with wrap, -1 if none
    function automatic int first_from(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic int model_winner(input logic rn, input logic fl,
                                        input logic [N-1:0] r, input logic [N-1:0] u);
        logic [N-1:0] m;
        if (!rn || fl) return -1;
        m = r;
`ifdef CDB_RR_ARBITER_URGENT_EN
        if ((r & u) != 0) m = r & u;
`endif
        return first_from(m, m_ptr);
    endfunction

    task automatic step(input logic rn, input logic fl, input logic [N-1:0] r,
                        input logic [N-1:0] u, input logic [N*TW-1:0] t,
                        input logic [N*DW-1:0] d);
        int           w;
        logic [N-1:0] exp_g;
        rst_n = rn; flush = fl; req = r; urgent = u; req_tag = t; req_data = d;
        #1;
        w     = model_winner(rn, fl, r, u);
        exp_g = (w >= 0) ? (N'(1) << w) : '0;
        checks++;
        assert (grant === exp_g) else begin
            errors++;
            $error("FAIL grant got=%b exp=%b (ptr=%0d req=%b)", grant, exp_g, m_ptr, r);
        end
        @(posedge clk);
        if (!rn) begin
            m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_src = 0;
        end else if (w >= 0) begin
            m_valid = 1'b1;
            m_tag   = t[w*TW +: TW];
            m_data  = d[w*DW +: DW];
            m_src   = w;
            m_ptr   = (w + 1) % N;
        end else begin
            m_valid = 1'b0;
        end
        #1;
        checks++;
        assert (cdb_valid === m_valid) else begin
            errors++;
            $error("FAIL cdb_valid got=%b exp=%b", cdb_valid, m_valid);
        end
        checks++;
        assert ({cdb_tag, cdb_data, cdb_src} === {m_tag, m_data, 2'(m_src)}) else begin
            errors++;
            $error("FAIL cdb_word got=%h/%h/%0d exp=%h/%h/%0d",
                   cdb_tag, cdb_data, cdb_src, m_tag, m_data, m_src);
        end
        @(negedge clk);
    endtask

    initial begin
        m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_src = 0;
        @(negedge clk);
        // reset with all requesting
        step(0, 0, 3'b111, 3'b000, 12'h321, 12'hCBA);
        step(0, 0, 3'b111, 3'b000, 12'h321, 12'hCBA);
        // release: producer 0 first
        step(1, 0, 3'b111, 3'b000, 12'h321, 12'hCBA);
        // single requester 1, tag 5 data A
        step(1, 0, 3'b010, 3'b000, 12'h050, 12'h0A0);
        step(1, 0, 3'b000, 3'b000, 12'h000, 12'h000);
        // bring pointer back to 0, then rotate six cycles
        step(1, 0, 3'b100, 3'b000, 12'h700, 12'h800);
        for (int i = 0; i < 6; i++)
            step(1, 0, 3'b111, 3'b000, 12'(i * 12'h111), 12'(12'hFED - i));
        // pointer to 2, then wrap/skip
        step(1, 0, 3'b010, 3'b000, 12'h040, 12'h030);
        step(1, 0, 3'b011, 3'b000, 12'h09E, 12'h01F);
        step(1, 0, 3'b010, 3'b000, 12'h090, 12'h010);
        // flush squashes the grant but not the already-registered word
        step(1, 1, 3'b100, 3'b000, 12'hB00, 12'hC00);
        step(1, 0, 3'b100, 3'b000, 12'hB00, 12'hC00);
`ifdef CDB_RR_ARBITER_URGENT_EN
        step(1, 0, 3'b111, 3'b100, 12'h123, 12'h456);
        step(1, 0, 3'b111, 3'b000, 12'h123, 12'h456);
`endif
        // random traffic including mid-run reset and flush
        for (int i = 0; i < 400; i++)
            step(($urandom_range(39) != 0), ($urandom_range(7) == 0),
                 N'($urandom), N'($urandom), 12'($urandom), 12'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
- Round-robin arbiter that shares the single common data bus (CDB) between result producers: ALU execution unit, future load/store and multiply units.
- Each cycle it grants at most one requester and latches that requester's tag/data into a registered CDB stage.
- The registered stage drives every CDB consumer: reservation stations and the register file controller.
- Replaces fixed-priority selection with fair, starvation-free sharing.

Parameters:
- REQUESTERS, 3, number of CDB producers (>=1)
- DATA_WIDTH, 4, bitwidth of a data word
- CDB_TAG_WIDTH, 4, bitwidth of a CDB tag (<= DATA_WIDTH)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- flush  input  1  synchronous squash: drop current selection, invalidate CDB stage
- req  input  REQUESTERS  per-producer broadcast request
- req_tag  input  REQUESTERS*CDB_TAG_WIDTH  packed tags; producer i at [i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH]
- req_data  input  REQUESTERS*DATA_WIDTH  packed data; producer i at [i*DATA_WIDTH +: DATA_WIDTH]
- grant  output  REQUESTERS  one-hot (or zero) combinational grant
- cdb_valid  output  1  registered CDB valid
- cdb_tag  output  CDB_TAG_WIDTH  registered CDB tag
- cdb_data  output  DATA_WIDTH  registered CDB data
- cdb_src  output  max(1,$clog2(REQUESTERS))  index of producer driving the current CDB word

Behaviour:
- State: rr_ptr (index width), output registers cdb_valid/cdb_tag/cdb_data/cdb_src.
- Reset (rst_n=0 at posedge): rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0. While rst_n=0, grant=0 combinationally.
- Selection (combinational): scan req from index rr_ptr upward, wrapping REQUESTERS-1 -> 0. The first asserted bit wins. grant is one-hot on the winner, otherwise all zero.
- Grant handshake:
  - grant[i]=1 in cycle t means producer i's word is taken at the posedge ending cycle t.
  - The producer deasserts req[i] or presents its next word in cycle t+1.
  - The producer must hold req/tag/data stable until granted.
  - Withdrawing req before grant is legal; nothing is broadcast for it.
- Latency: word granted in cycle t appears on cdb_valid/tag/data in cycle t+1 and is valid exactly one cycle.
- Posedge update with a winner i: cdb_valid<=1, cdb_tag<=req_tag[i], cdb_data<=req_data[i], cdb_src<=i, rr_ptr<=(i+1) wrapped (i=REQUESTERS-1 -> 0).
- Posedge update with no request: cdb_valid<=0; tag/data/src hold their old values; rr_ptr unchanged.
- flush=1 (and rst_n=1):
  - grant forced 0 that cycle, so no producer is consumed.
  - Next cycle cdb_valid=0; rr_ptr unchanged.
  - flush does not affect an already-registered word in its own cycle; that word is still visible for that cycle.
- Back-to-back: a producer may win in consecutive cycles only if no other request is present (pointer moves past it).
- Fairness bound: a continuously requesting producer is granted within REQUESTERS cycles.
- REQUESTERS=1: grant=req & ~flush; rr_ptr stays 0.
- Reset mid-operation: a pending grant is discarded and the CDB word is invalidated on that edge.
- No combinational path from cdb_* outputs back to grant.

Optional Feature:
- Macro CDB_RR_ARBITER_URGENT_EN.
- Defined:
  - Adds input urgent (REQUESTERS bits).
  - Requesters with req&urgent are selected first, by the same round-robin scan restricted to req&urgent.
  - If none are urgent, plain round-robin applies.
  - rr_ptr updates identically after any grant.
- Not defined: no urgent port; pure round-robin as above.

Test Plan:
- Reset: rst_n=0 with req=3'b111 for 2 cycles -> grant=0, cdb_valid=0, cdb_tag=0, cdb_data=0. Release; first grant=3'b001.
- Single requester: req=3'b010, tag=4'h5, data=4'hA in cycle t -> grant=3'b010 in t; cycle t+1 cdb_valid=1, tag=5, data=A, src=1; cycle t+2 cdb_valid=0 after req drops.
- Rotation: req=3'b111 held 6 cycles from rr_ptr=0 -> grant sequence 001,010,100,001,010,100; cdb_src 0,1,2,0,1,2 one cycle later.
- Wrap/skip: rr_ptr=2, req=3'b011 -> grant=001, then (req=3'b010) grant=010.
- Flush: req=3'b100, flush=1 -> grant=0, next cdb_valid=0, rr_ptr unchanged. flush=0 next cycle -> grant=100.
- Urgent (macro defined): req=3'b111, urgent=3'b100, rr_ptr=0 -> grant=100. Then urgent=0 -> grant=001.
